mux_ser8: RTL and testbench
===========================

MUX_SER8 -- requirements
Module: mux_ser8

Interface
REQ-001 Parameter: LSB_FIRST, default 1, 1 = select order 0..7; 0 = select order 7..0.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: load_valid  input  1  upstream offers a byte on din.
REQ-005 Port: load_ready  output  1  block can accept a byte.
REQ-006 Port: din  input  8  parallel byte; bit k maps to 8:1 mux input ik.
REQ-007 Port: sel  output  3  mux select {s2,s1,s0}, driven from a registered counter.
REQ-008 Port: sout  output  1  serial bit, equal to captured_byte[sel] while valid.
REQ-009 Port: sout_valid  output  1  sout carries a data (or parity) bit this cycle.
REQ-010 Port: done  output  1  one-cycle pulse on the last bit of a frame.
REQ-011 Clocking and reset are fixed: one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-012 Block shall be a parallel-in, serial-out stage, with an internal 8:1 selection of the captured byte indexed by sel.
REQ-013 States: IDLE, SHIFT, and PAR (PAR exists only under MUX_SER8_PARITY_EN).
REQ-014 IDLE: load_ready=1, sout_valid=0, sout=0, and sel holds its start value (0 if LSB_FIRST=1, 7 otherwise).
REQ-015 Handshake: a byte is accepted only on a clk edge where load_valid=1 and load_ready=1; din is captured into an internal register and the state moves to SHIFT.
REQ-016 Latency: the first bit appears on sout, with sout_valid=1, in the cycle immediately after acceptance.
REQ-017 SHIFT: sel steps by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0) each cycle, and sout is the captured bit at sel.
REQ-018 A frame spans exactly 8 consecutive SHIFT cycles, with no gaps.
REQ-019 Last data bit, sel wraps 7 to 0 (or 0 to 7): without parity, done=1 that cycle and the next state is IDLE; with parity, the next state is PAR and done=0.
REQ-020 load_ready shall be 0 in SHIFT and PAR, and load_valid is ignored there; there is no back-to-back acceptance.
REQ-021 The next byte can be accepted in the first IDLE cycle after a frame, giving a minimum period of 9 cycles (10 with parity).
REQ-022 The captured byte is held stable for the whole frame, regardless of changes on din.
REQ-023 sel shall return to its start value on every entry to IDLE.

Reset
REQ-024 When rst=1 at a clk edge, the block enters IDLE, whatever state it was in.
REQ-025 Reset values: load_ready=1, sout=0, sout_valid=0, done=0, sel=start value, captured byte=8'h00.
REQ-026 Reset mid-frame aborts the frame with no done pulse; sout_valid=0 in the cycle after the reset edge.
REQ-027 load_valid is ignored on any edge where rst=1.

Configuration
REQ-028 The macro MUX_SER8_PARITY_EN controls the parity bit.
REQ-029 With MUX_SER8_PARITY_EN defined: after the 8 data bits, PAR drives sout = even parity (XOR of the captured byte) for one cycle, with sout_valid=1 and done=1; sel holds its last value during PAR.
REQ-030 Without MUX_SER8_PARITY_EN: the PAR state and parity logic are absent, and the frame is 8 cycles.

Verification
REQ-031 Basic LSB-first frame: LSB_FIRST=1, din=8'b10101010 accepted -> over the next 8 cycles, sel=0..7 and sout=0,1,0,1,0,1,0,1; done on the 8th cycle.
REQ-032 MSB-first frame: LSB_FIRST=0, din=8'hA5 -> sel=7..0 and sout=1,0,1,0,0,1,0,1; load_ready=0 throughout.
REQ-033 Held handshake: load_valid held at 1 with din=8'hFF then 8'h00 -> the second byte is accepted on the first IDLE cycle (cycle 9), and its first bit appears on cycle 10.
REQ-034 Reset mid-frame: rst=1 at bit 4 of 8'h3C -> next cycle sout_valid=0, load_ready=1, sel=start value, and no done pulse.
REQ-035 Parity: MUX_SER8_PARITY_EN defined, din=8'h07 -> the 9th bit is 1 with done=1 on that cycle; with din=8'h03 the 9th bit is 0.
REQ-036 Input stability: din changed every cycle during SHIFT -> the serial output still matches the byte captured at acceptance.

Source files
------------

// File: rtl/mux_ser8.sv
// Parallel-in serial-out byte stage built around an 8:1 select of a captured byte.
// Define MUX_SER8_PARITY_EN to append an even-parity bit after the 8 data bits.
module mux_ser8 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] din,
    output logic [2:0] sel,
    output logic       sout,
    output logic       sout_valid,
    output logic       done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef MUX_SER8_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    localparam logic [2:0] SEL_START = LSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [2:0] SEL_LAST  = LSB_FIRST ? 3'd7 : 3'd0;

    logic [1:0] r_state;
    logic [2:0] r_sel;
    logic [7:0] r_byte;

    logic       w_last;
    logic [2:0] w_sel_next;

    assign w_last     = (r_sel == SEL_LAST);
    assign w_sel_next = LSB_FIRST ? (r_sel + 3'd1) : (r_sel - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_START;
            r_byte  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sel <= SEL_START;
                    if (load_valid) begin
                        r_byte  <= din;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
`ifdef MUX_SER8_PARITY_EN
                        // sel parks on the last data bit through PAR
                        r_state <= ST_PAR;
`else
                        r_state <= ST_IDLE;
                        r_sel   <= SEL_START;
`endif
                    end else begin
                        r_sel <= w_sel_next;
                    end
                end
`ifdef MUX_SER8_PARITY_EN
                ST_PAR: begin
                    r_state <= ST_IDLE;
                    r_sel   <= SEL_START;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= SEL_START;
                end
            endcase
        end
    end

    always_comb begin
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                sout       = r_byte[r_sel];
                sout_valid = 1'b1;
`ifndef MUX_SER8_PARITY_EN
                done       = w_last;
`endif
            end
`ifdef MUX_SER8_PARITY_EN
            ST_PAR: begin
                sout       = ^r_byte;
                sout_valid = 1'b1;
                done       = 1'b1;
            end
`endif
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    assign sel = r_sel;

endmodule

// File: tb/tb_mux_ser8.sv
// Directed self-checking bench for mux_ser8, LSB-first and MSB-first instances.
// Parity expectations follow MUX_SER8_PARITY_EN as defined for the build.
module tb_mux_ser8;

`ifdef MUX_SER8_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       lv_l, lv_m;
    logic [7:0] din_l, din_m;
    logic       rdy_l, rdy_m;
    logic [2:0] sel_l, sel_m;
    logic       sout_l, sout_m;
    logic       sv_l, sv_m;
    logic       done_l, done_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_ser8 #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(lv_l), .load_ready(rdy_l),
        .din(din_l), .sel(sel_l), .sout(sout_l), .sout_valid(sv_l),
        .done(done_l)
    );

    mux_ser8 #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .load_valid(lv_m), .load_ready(rdy_m),
        .din(din_m), .sel(sel_m), .sout(sout_m), .sout_valid(sv_m),
        .done(done_m)
    );

    // packed view: {sel, sout, sout_valid, done, load_ready}
    function automatic logic [6:0] obs(input bit msb);
        return msb ? {sel_m, sout_m, sv_m, done_m, rdy_m}
                   : {sel_l, sout_l, sv_l, done_l, rdy_l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit msb, input logic v, input logic [7:0] d);
        if (msb) begin
            lv_m = v; din_m = d;
        end else begin
            lv_l = v; din_l = d;
        end
    endtask

    task automatic run_frame(input bit msb, input logic [7:0] b,
                             input bit wiggle, input bit hold,
                             input logic [7:0] next_d, input string name);
        logic [6:0] exp;
        logic [6:0] got;
        logic [2:0] es;
        logic [2:0] st;
        st = msb ? 3'd7 : 3'd0;
        drive(msb, 1'b1, b);
        step();
        drive(msb, hold, next_d);
        for (int k = 0; k < 8; k++) begin
            es  = msb ? 3'(7 - k) : 3'(k);
            exp = {es, b[es], 1'b1, (k == 7) && !PAR_EN, 1'b0};
            got = obs(msb);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s bit%0d: got %b expected %b", name, k, got, exp);
            end
            if (wiggle) drive(msb, 1'b0, 8'($urandom));
            step();
        end
        if (PAR_EN) begin
            exp = {(msb ? 3'd0 : 3'd7), ^b, 1'b1, 1'b1, 1'b0};
            got = obs(msb);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s parity: got %b expected %b", name, got, exp);
            end
            step();
        end
        exp = {st, 1'b0, 1'b0, 1'b0, 1'b1};
        got = obs(msb);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s idle: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 8'hFF);
        step();
        step();
        n_checks++;
        if (obs(1'b0) !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL reset_lsb: got %b expected %b", obs(1'b0), 7'b000_0001);
        end
        n_checks++;
        if (obs(1'b1) !== 7'b111_0001) begin
            n_fail++;
            $display("FAIL reset_msb: got %b expected %b", obs(1'b1), 7'b111_0001);
        end
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        step();
        n_checks++;
        if (obs(1'b0) !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL idle_hold: got %b expected %b", obs(1'b0), 7'b000_0001);
        end
    endtask

    task automatic test_lsb_frame();
        run_frame(1'b0, 8'b1010_1010, 1'b0, 1'b0, 8'h00, "lsb_aa");
        step();
        run_frame(1'b0, 8'h07, 1'b0, 1'b0, 8'h00, "lsb_07");
        run_frame(1'b0, 8'h03, 1'b0, 1'b0, 8'h00, "lsb_03");
    endtask

    task automatic test_msb_frame();
        run_frame(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, "msb_a5");
        run_frame(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, "msb_07");
    endtask

    task automatic test_back_to_back();
        logic [6:0] got;
        run_frame(1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, "held_ff");
        step();
        drive(1'b0, 1'b0, 8'hFF);
        got = obs(1'b0);
        n_checks++;
        if (got !== 7'b000_0100) begin
            n_fail++;
            $display("FAIL held_next_first: got %b expected %b", got, 7'b000_0100);
        end
        repeat (8 + int'(PAR_EN)) step();
        got = obs(1'b0);
        n_checks++;
        if (got !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL held_next_idle: got %b expected %b", got, 7'b000_0001);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] got;
        drive(1'b0, 1'b1, 8'h3C);
        step();
        drive(1'b0, 1'b0, 8'h00);
        repeat (4) step();
        got = obs(1'b0);
        n_checks++;
        if (got !== 7'b100_1100) begin
            n_fail++;
            $display("FAIL rst_pre_bit4: got %b expected %b", got, 7'b100_1100);
        end
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'hFF);
        step();
        got = obs(1'b0);
        n_checks++;
        if (got !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL rst_mid_frame: got %b expected %b", got, 7'b000_0001);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        step();
        got = obs(1'b0);
        n_checks++;
        if (got !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL rst_lv_ignored: got %b expected %b", got, 7'b000_0001);
        end
    endtask

    task automatic test_din_stability();
        run_frame(1'b0, 8'h96, 1'b1, 1'b0, 8'h69, "stab_lsb");
        run_frame(1'b1, 8'h5B, 1'b1, 1'b0, 8'hA4, "stab_msb");
    endtask

    initial begin
        test_reset();
        test_lsb_frame();
        test_msb_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_din_stability();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
